// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM entry layout, slot record and evaluator state encoding.
package ppu_pkg;

  localparam int OAM_ENTRIES = 64;
  localparam int OAM_ADDR_W  = 6;

  localparam int ATTR_HI = 31;
  localparam int ATTR_LO = 24;
  localparam int TILE_HI = 23;
  localparam int TILE_LO = 16;
  localparam int Y_HI    = 15;
  localparam int Y_LO    = 8;
  localparam int X_HI    = 7;
  localparam int X_LO    = 0;

  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_SEL_W = 3;
  localparam int SLOT_CNT_W = 4;
  localparam int ROW_W      = 3;

  typedef struct packed {
    logic [7:0]       attr;
    logic [7:0]       tile;
    logic [7:0]       x;
    logic [ROW_W-1:0] row;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } eval_state_e;

  function automatic slot_t make_slot(input logic [31:0] entry, input logic [ROW_W-1:0] row);
    slot_t s;
    s.attr = entry[ATTR_HI:ATTR_LO];
    s.tile = entry[TILE_HI:TILE_LO];
    s.x    = entry[X_HI:X_LO];
    s.row  = row;
    return s;
  endfunction

endpackage

// File: rtl/sprite_slot_bank.sv
// Double-buffered sprite slot bank: the evaluator appends into the back bank,
// the renderer reads the front bank, and swap publishes back to front.
module sprite_slot_bank
  import ppu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  slot_t                 push_slot,
  input  logic                  set_ovf,
  input  logic                  swap,
  input  logic [SLOT_SEL_W-1:0] rd_sel,
  output slot_t                 rd_slot,
  output logic [SLOT_CNT_W-1:0] back_count,
  output logic [SLOT_CNT_W-1:0] front_count,
  output logic                  front_ovf
);

  slot_t                 back_r  [NUM_SLOTS];
  slot_t                 front_r [NUM_SLOTS];
  logic [SLOT_CNT_W-1:0] back_cnt_r;
  logic [SLOT_CNT_W-1:0] front_cnt_r;
  logic                  back_ovf_r;
  logic                  front_ovf_r;

  // Back bank fill/clear and front bank publish; clear+swap publishes an empty bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        back_r[i]  <= '0;
        front_r[i] <= '0;
      end
      back_cnt_r  <= '0;
      front_cnt_r <= '0;
      back_ovf_r  <= 1'b0;
      front_ovf_r <= 1'b0;
    end else begin
      if (clear) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          back_r[i] <= '0;
        end
        back_cnt_r <= '0;
        back_ovf_r <= 1'b0;
      end else begin
        if (push) begin
          back_r[back_cnt_r[SLOT_SEL_W-1:0]] <= push_slot;
          back_cnt_r <= back_cnt_r + SLOT_CNT_W'(1);
        end
        if (set_ovf) begin
          back_ovf_r <= 1'b1;
        end
      end
      if (swap) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          front_r[i] <= clear ? '0 : back_r[i];
        end
        front_cnt_r <= clear ? '0 : back_cnt_r;
        front_ovf_r <= clear ? 1'b0 : back_ovf_r;
      end
    end
  end

  // Zero-latency renderer read of the published bank.
  always_comb begin
    rd_slot = front_r[rd_sel];
  end

  assign back_count  = back_cnt_r;
  assign front_count = front_cnt_r;
  assign front_ovf   = front_ovf_r;

endmodule

// File: rtl/sprite_evaluator.sv
// Per-line sprite evaluator: scans OAM during hblank, collects up to MAX_SLOTS
// sprites covering the next line, and publishes them at end of line.
module sprite_evaluator
  import ppu_pkg::*;
#(
  parameter int H_EVAL_START = 640,
  parameter int H_SWAP       = 799,
  parameter int V_VISIBLE    = 480,
  parameter int V_TOTAL      = 525,
  parameter int LINE_SHIFT   = 1,
  parameter int SPRITE_H     = 8,
  parameter int MAX_SLOTS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            hCount,
  input  logic [9:0]            vCount,
  output logic                  oam_rd_en,
  output logic [OAM_ADDR_W-1:0] oam_rd_addr,
  input  logic [31:0]           oam_rd_data,
  input  logic [SLOT_SEL_W-1:0] slot_sel,
  output logic                  slot_valid,
  output logic [7:0]            slot_attr,
  output logic [7:0]            slot_tile,
  output logic [7:0]            slot_x,
  output logic [ROW_W-1:0]      slot_row,
  output logic [SLOT_CNT_W-1:0] slot_count,
  output logic                  sprite_overflow,
  output logic                  eval_busy
);

  if (H_EVAL_START + 66 > H_SWAP) begin : g_bad_timing
    $error("sprite_evaluator: H_SWAP must be at least H_EVAL_START + 66");
  end

  localparam logic [9:0]            H_START_C  = 10'(H_EVAL_START);
  localparam logic [9:0]            H_SWAP_C   = 10'(H_SWAP);
  localparam logic [9:0]            V_VIS_C    = 10'(V_VISIBLE);
  localparam logic [9:0]            V_LAST_C   = 10'(V_TOTAL - 1);
  localparam logic [7:0]            SPR_H_C    = 8'(SPRITE_H);
  localparam logic [SLOT_CNT_W-1:0] MAX_C      = SLOT_CNT_W'(MAX_SLOTS);
  localparam logic [OAM_ADDR_W-1:0] OAM_LAST_C = OAM_ADDR_W'(OAM_ENTRIES - 1);

  eval_state_e           state_r;
  logic                  rd_en_r;
  logic [OAM_ADDR_W-1:0] rd_addr_r;
  logic                  data_vld_r;
  logic                  busy_r;
  logic [7:0]            sl_r;

  logic [9:0]            tl_s;
  logic [7:0]            sl_s;
  logic                  skip_s;
  logic [8:0]            d_s;
  logic                  in_range_s;
  logic                  eval_vld_s;
  logic                  full_s;
  logic                  push_s;
  logic                  ovf_s;
  logic                  start_hit_s;
  logic                  swap_hit_s;
  logic                  busy_state_s;
  logic                  clear_s;
  logic                  swap_s;
  slot_t                 push_slot_s;
  slot_t                 rd_slot_s;
  logic [SLOT_CNT_W-1:0] back_count_s;

  assign tl_s         = (vCount == V_LAST_C) ? 10'd0 : vCount + 10'd1;
  assign sl_s         = 8'(tl_s >> LINE_SHIFT);
  assign skip_s       = (tl_s >= V_VIS_C);
  assign start_hit_s  = (hCount == H_START_C);
  assign swap_hit_s   = (hCount == H_SWAP_C);
  assign busy_state_s = (state_r == ST_SCAN) || (state_r == ST_DRAIN);

  // Unsigned 9-bit difference: bit 8 set means Y lies below the line, so no wrap-around hits.
  assign d_s          = {1'b0, sl_r} - {1'b0, oam_rd_data[Y_HI:Y_LO]};
  assign in_range_s   = !d_s[8] && (d_s[7:0] < SPR_H_C);
  assign eval_vld_s   = data_vld_r && busy_state_s;
  assign full_s       = (back_count_s == MAX_C);
  assign push_slot_s  = make_slot(oam_rd_data, d_s[ROW_W-1:0]);

  // Hit classification of the entry returned this clock.
  always_comb begin
    push_s = 1'b0;
    ovf_s  = 1'b0;
    if (eval_vld_s && in_range_s) begin
      if (full_s) begin
        ovf_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      ovf_s  = 1'b0;
    end
  end

  assign clear_s = ((state_r == ST_IDLE) && start_hit_s) || (busy_state_s && swap_hit_s);
  assign swap_s  = swap_hit_s && (state_r != ST_IDLE);

  // Evaluation FSM with its read strobe, address counter and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      rd_en_r    <= 1'b0;
      rd_addr_r  <= '0;
      data_vld_r <= 1'b0;
      busy_r     <= 1'b0;
      sl_r       <= 8'd0;
    end else begin
      data_vld_r <= rd_en_r;
      case (state_r)
        ST_IDLE: begin
          if (start_hit_s) begin
            sl_r <= sl_s;
            if (skip_s) begin
              state_r <= ST_DONE;
            end else begin
              state_r   <= ST_SCAN;
              rd_en_r   <= 1'b1;
              rd_addr_r <= '0;
              busy_r    <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (swap_hit_s) begin
            state_r <= ST_IDLE;
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (ovf_s || (rd_addr_r == OAM_LAST_C)) begin
            state_r <= ST_DRAIN;
            rd_en_r <= 1'b0;
          end else begin
            rd_addr_r <= rd_addr_r + OAM_ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          busy_r  <= 1'b0;
          state_r <= swap_hit_s ? ST_IDLE : ST_DONE;
        end
        ST_DONE: begin
          if (swap_hit_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rd_en_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  sprite_slot_bank u_bank (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_s),
    .push        (push_s),
    .push_slot   (push_slot_s),
    .set_ovf     (ovf_s),
    .swap        (swap_s),
    .rd_sel      (slot_sel),
    .rd_slot     (rd_slot_s),
    .back_count  (back_count_s),
    .front_count (slot_count),
    .front_ovf   (sprite_overflow)
  );

  assign oam_rd_en   = rd_en_r;
  assign oam_rd_addr = rd_addr_r;
  assign eval_busy   = busy_r;
  assign slot_valid  = ({1'b0, slot_sel} < slot_count);
  assign slot_attr   = rd_slot_s.attr;
  assign slot_tile   = rd_slot_s.tile;
  assign slot_x      = rd_slot_s.x;
  assign slot_row    = rd_slot_s.row;

endmodule

// File: tb/tb_sprite_evaluator.sv
// Self-checking bench: drives whole VGA lines, models OAM and the per-line sprite pick,
// and compares every output on every clock.
module tb_sprite_evaluator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hCount = 10'd0;
  logic [9:0]  vCount = 10'd0;
  logic        oam_rd_en;
  logic [5:0]  oam_rd_addr;
  logic [31:0] oam_rd_data = 32'd0;
  logic [2:0]  slot_sel = 3'd0;
  logic        slot_valid;
  logic [7:0]  slot_attr;
  logic [7:0]  slot_tile;
  logic [7:0]  slot_x;
  logic [2:0]  slot_row;
  logic [3:0]  slot_count;
  logic        sprite_overflow;
  logic        eval_busy;

  always #20 clk = ~clk;

  sprite_evaluator dut (
    .clk             (clk),
    .reset           (reset),
    .hCount          (hCount),
    .vCount          (vCount),
    .oam_rd_en       (oam_rd_en),
    .oam_rd_addr     (oam_rd_addr),
    .oam_rd_data     (oam_rd_data),
    .slot_sel        (slot_sel),
    .slot_valid      (slot_valid),
    .slot_attr       (slot_attr),
    .slot_tile       (slot_tile),
    .slot_x          (slot_x),
    .slot_row        (slot_row),
    .slot_count      (slot_count),
    .sprite_overflow (sprite_overflow),
    .eval_busy       (eval_busy)
  );

  // OAM RAM: registered read, data one clock after the strobe.
  logic [31:0] oam [64];
  always @(posedge clk) begin
    if (oam_rd_en) oam_rd_data <= oam[oam_rd_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state.
  int          cur_h = 0;
  bit          scan_en = 1'b0;
  bit          aborted = 1'b0;
  int          nreads = 0;
  int          bk_cnt = 0;
  bit          bk_ovf = 1'b0;
  logic [26:0] bk_slot [8];
  int          fr_cnt = 0;
  bit          fr_ovf = 1'b0;
  logic [26:0] fr_slot [8];
  bit          chk_en = 1'b0;
  int          rd_total = 0;
  int          busy_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Which sprites the next line needs, straight from the hit rule applied in OAM order.
  task automatic model_line(input int v);
    int tl;
    int sl;
    int y;
    bk_cnt = 0;
    bk_ovf = 1'b0;
    nreads = 0;
    for (int i = 0; i < 8; i++) bk_slot[i] = 27'd0;
    tl = (v == 524) ? 0 : v + 1;
    scan_en = (tl < 480);
    if (scan_en) begin
      sl = tl / 2;
      nreads = 64;
      for (int e = 0; e < 64; e++) begin
        y = oam[e][15:8];
        if (y <= sl && sl - y < 8) begin
          if (bk_cnt < 8) begin
            bk_slot[bk_cnt] = {oam[e][31:24], oam[e][23:16], oam[e][7:0], 3'(sl - y)};
            bk_cnt++;
          end else begin
            bk_ovf = 1'b1;
            nreads = (e + 2 > 64) ? 64 : e + 2;
            break;
          end
        end
      end
    end
  endtask

  // Per-clock comparison against the model.
  always @(negedge clk) begin : cmp
    int          rel;
    bit          live;
    bit          exp_rd;
    bit          exp_busy;
    logic [26:0] es;
    if (chk_en) begin
      if (oam_rd_en) rd_total++;
      if (eval_busy) busy_total++;
      live     = scan_en && !aborted;
      rel      = cur_h - 641;
      exp_rd   = live && rel >= 0 && rel < nreads;
      exp_busy = live && rel >= 0 && rel <= nreads;
      chk("oam_rd_en", oam_rd_en, exp_rd);
      if (exp_rd) chk("oam_rd_addr", oam_rd_addr, rel);
      chk("eval_busy", eval_busy, exp_busy);
      es = fr_slot[slot_sel];
      chk("slot_count", slot_count, fr_cnt);
      chk("sprite_overflow", sprite_overflow, fr_ovf);
      chk("slot_valid", slot_valid, (slot_sel < fr_cnt));
      chk("slot_attr", slot_attr, es[26:19]);
      chk("slot_tile", slot_tile, es[18:11]);
      chk("slot_x", slot_x, es[10:3]);
      chk("slot_row", slot_row, es[2:0]);
    end
  end

  task automatic run_line(input int v, input int rst_h);
    model_line(v);
    aborted = 1'b0;
    for (int h = 0; h < 800; h++) begin
      cur_h    = h;
      hCount   = 10'(h);
      vCount   = 10'(v);
      slot_sel = 3'($urandom);
      reset    = (h == rst_h);
      @(posedge clk);
      #1;
      if (h == rst_h) begin
        aborted = 1'b1;
        fr_cnt  = 0;
        fr_ovf  = 1'b0;
        for (int i = 0; i < 8; i++) fr_slot[i] = 27'd0;
        chk("reset_busy_lit", eval_busy, 0);
        chk("reset_rden_lit", oam_rd_en, 0);
        chk("reset_count_lit", slot_count, 0);
      end
    end
    reset = 1'b0;
    if (!aborted) begin
      fr_cnt = bk_cnt;
      fr_ovf = bk_ovf;
      for (int i = 0; i < 8; i++) fr_slot[i] = bk_slot[i];
    end
  endtask

  task automatic oam_blank();
    for (int i = 0; i < 64; i++) oam[i] = 32'h0000_FF00;
  endtask

  initial begin : stim
    int rd0;
    int bz0;
    oam_blank();
    for (int i = 0; i < 8; i++) begin
      bk_slot[i] = 27'd0;
      fr_slot[i] = 27'd0;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_count", slot_count, 0);
    chk("rst_busy", eval_busy, 0);
    chk("rst_rden", oam_rd_en, 0);
    reset = 1'b0;

    // Single sprite at Y=0x64, line 100, plus read/busy window lengths.
    oam[0] = 32'h01_00_64_64;
    rd0 = rd_total;
    bz0 = busy_total;
    run_line(199, -1);
    slot_sel = 3'd0;
    #1;
    chk("t1_count", slot_count, 1);
    chk("t1_attr", slot_attr, 8'h01);
    chk("t1_tile", slot_tile, 8'h00);
    chk("t1_x", slot_x, 8'h64);
    chk("t1_row", slot_row, 0);
    chk("t1_ovf", sprite_overflow, 0);
    chk("t4_rd_clks", rd_total - rd0, 64);
    chk("t4_busy_clks", busy_total - bz0, 65);

    run_line(214, -1);
    slot_sel = 3'd0;
    #1;
    chk("t2_row7", slot_row, 7);
    chk("t2_count", slot_count, 1);
    run_line(215, -1);
    #1;
    chk("t2_miss_count", slot_count, 0);

    // Nine sprites on one line: eight kept in order, overflow, early read stop.
    oam_blank();
    for (int i = 0; i < 9; i++) oam[i] = {8'(8'h10 + i), 8'(i), 8'h32, 8'(i * 10)};
    rd0 = rd_total;
    bz0 = busy_total;
    run_line(99, -1);
    chk("t3_count", slot_count, 8);
    chk("t3_ovf", sprite_overflow, 1);
    chk("t3_rd_clks", rd_total - rd0, 10);
    chk("t3_busy_clks", busy_total - bz0, 11);
    for (int i = 0; i < 8; i++) begin
      slot_sel = 3'(i);
      #1;
      chk("t3_tile_order", slot_tile, i);
    end

    // Reset mid-scan, then recovery on the following line.
    oam_blank();
    oam[0] = 32'h01_00_64_64;
    run_line(199, 660);
    #1;
    chk("t6_count_after", slot_count, 0);
    run_line(199, -1);
    slot_sel = 3'd0;
    #1;
    chk("t6_recover_count", slot_count, 1);
    chk("t6_recover_x", slot_x, 8'h64);

    // Frame wrap to line 0 and the first invisible target line.
    oam_blank();
    oam[0] = 32'h02_05_00_07;
    run_line(524, -1);
    slot_sel = 3'd0;
    #1;
    chk("t5_wrap_count", slot_count, 1);
    chk("t5_wrap_row", slot_row, 0);
    chk("t5_wrap_tile", slot_tile, 5);
    rd0 = rd_total;
    run_line(479, -1);
    #1;
    chk("t5_skip_rd_clks", rd_total - rd0, 0);
    chk("t5_skip_count", slot_count, 0);

    // Randomized OAM contents and lines.
    for (int k = 0; k < 16; k++) begin
      int v;
      int tl;
      int sl;
      int dens;
      int yv;
      v = (k % 4 == 3) ? $urandom_range(0, 524) : $urandom_range(0, 478);
      tl = (v == 524) ? 0 : v + 1;
      sl = tl / 2;
      dens = $urandom_range(0, 24);
      for (int e = 0; e < 64; e++) begin
        if ($urandom_range(0, 63) < dens) yv = (sl - $urandom_range(0, 9)) & 255;
        else yv = $urandom_range(0, 255);
        oam[e] = {8'($urandom), 8'($urandom), 8'(yv), 8'($urandom)};
      end
      run_line(v, -1);
    end
    run_line(10, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
